wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 122 ++++++++++++
 tb/tb_wb_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: two-port write arbiter in front of a register file.
// Grants one of two write requesters per cycle, registers the winning write
// into a one-deep output stage that drives RW/DA/D_Data, and counts
// contention cycles.
// Optional feature: define WB_BYPASS_EN to forward the in-flight write
// (RW/DA/D_Data) onto the A_Data/B_Data read ports.
//
// Handshake: a write transfers on a rising CLK edge where pN_valid and
// pN_ready are both high. pN_ready is combinational from the valids and
// last_grant, never high without its own valid, and never high on both
// ports together. A requester keeps valid and its payload stable until it
// sees ready at an edge.
module wb_arbiter #(
    parameter int FAIR = 1
) (
    input  logic        CLK,
    input  logic        reset_n,
    input  logic        p0_valid,
    input  logic [4:0]  p0_da,
    input  logic [31:0] p0_data,
    input  logic        p1_valid,
    input  logic [4:0]  p1_da,
    input  logic [31:0] p1_data,
    output logic        p0_ready,
    output logic        p1_ready,
    output logic        RW,
    output logic [4:0]  DA,
    output logic [31:0] D_Data,
    input  logic [4:0]  AA,
    input  logic [4:0]  BA,
    input  logic [31:0] A_Data_rf,
    input  logic [31:0] B_Data_rf,
    output logic [31:0] A_Data,
    output logic [31:0] B_Data,
    output logic [7:0]  conflict_cnt
);

    localparam logic FIXED_PRIO = (FAIR == 0);

    // last_grant: 0 = port 0 was granted last, 1 = port 1 was granted last
    logic        last_grant;
    logic        pick_p0;
    logic        xfer_p0;
    logic        xfer_p1;
    logic        xfer;
    logic [4:0]  sel_da;
    logic [31:0] sel_data;

    // On contention port 0 wins under fixed priority, or when port 1 went last
    assign pick_p0 = FIXED_PRIO | last_grant;

    // Grant logic; forced low while reset is asserted
    always_comb begin
        p0_ready = reset_n & p0_valid & (~p1_valid | pick_p0);
        p1_ready = reset_n & p1_valid & (~p0_valid | ~pick_p0);
    end

    assign xfer_p0  = p0_valid & p0_ready;
    assign xfer_p1  = p1_valid & p1_ready;
    assign xfer     = xfer_p0 | xfer_p1;
    assign sel_da   = xfer_p1 ? p1_da   : p0_da;
    assign sel_data = xfer_p1 ? p1_data : p0_data;

    // Remember which port took the last transfer (da=0 writes included)
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
        end else if (xfer_p0) begin
            last_grant <= 1'b0;
        end else if (xfer_p1) begin
            last_grant <= 1'b1;
        end
    end

    // Output stage: one-cycle RW pulse per real write; r0 writes are swallowed
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            RW     <= 1'b0;
            DA     <= 5'd0;
            D_Data <= 32'd0;
        end else if (xfer && (sel_da != 5'd0)) begin
            RW     <= 1'b1;
            DA     <= sel_da;
            D_Data <= sel_data;
        end else begin
            RW     <= 1'b0;
        end
    end

    // Saturating count of edges where both ports request
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            conflict_cnt <= 8'd0;
        end else if (p0_valid && p1_valid && (conflict_cnt != 8'hFF)) begin
            conflict_cnt <= conflict_cnt + 8'd1;
        end
    end

`ifdef WB_BYPASS_EN
    // Forward the write being committed this cycle to matching read ports
    always_comb begin
        A_Data = A_Data_rf;
        B_Data = B_Data_rf;
        if (RW && (DA == AA) && (AA != 5'd0)) begin
            A_Data = D_Data;
        end
        if (RW && (DA == BA) && (BA != 5'd0)) begin
            B_Data = D_Data;
        end
    end
`else
    // Read data passes straight through from the register file
    always_comb begin
        A_Data = A_Data_rf;
        B_Data = B_Data_rf;
    end

    logic unused_read_addr;
    assign unused_read_addr = ^{AA, BA};
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed, table-driven bench for wb_arbiter.
// u_rr is the round-robin build (FAIR=1), u_fx the fixed-priority build
// (FAIR=0); both share stimulus and reset.
module tb_wb_arbiter;

  logic        clk;
  logic        reset_n;
  logic        p0_valid;
  logic [4:0]  p0_da;
  logic [31:0] p0_data;
  logic        p1_valid;
  logic [4:0]  p1_da;
  logic [31:0] p1_data;
  logic [4:0]  aa;
  logic [4:0]  ba;
  logic [31:0] a_rf;
  logic [31:0] b_rf;

  logic        rr_p0_ready, rr_p1_ready, rr_rw;
  logic [4:0]  rr_da;
  logic [31:0] rr_d, rr_a, rr_b;
  logic [7:0]  rr_cnt;

  logic        fx_p0_ready, fx_p1_ready, fx_rw;
  logic [4:0]  fx_da;
  logic [31:0] fx_d, fx_a, fx_b;
  logic [7:0]  fx_cnt;

  int total;
  int bad;

  logic [36:0] exp_q[$];

  typedef struct {
    logic        v0;
    logic [4:0]  da0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  da1;
    logic [31:0] d1;
    logic        er0;
    logic        er1;
    logic        erw;
    logic [4:0]  eda;
    logic [31:0] ed;
  } vec_t;

  vec_t tbl[13];

  wb_arbiter #(.FAIR(1)) u_rr (
    .CLK(clk), .reset_n(reset_n),
    .p0_valid(p0_valid), .p0_da(p0_da), .p0_data(p0_data),
    .p1_valid(p1_valid), .p1_da(p1_da), .p1_data(p1_data),
    .p0_ready(rr_p0_ready), .p1_ready(rr_p1_ready),
    .RW(rr_rw), .DA(rr_da), .D_Data(rr_d),
    .AA(aa), .BA(ba), .A_Data_rf(a_rf), .B_Data_rf(b_rf),
    .A_Data(rr_a), .B_Data(rr_b), .conflict_cnt(rr_cnt)
  );

  wb_arbiter #(.FAIR(0)) u_fx (
    .CLK(clk), .reset_n(reset_n),
    .p0_valid(p0_valid), .p0_da(p0_da), .p0_data(p0_data),
    .p1_valid(p1_valid), .p1_da(p1_da), .p1_data(p1_data),
    .p0_ready(fx_p0_ready), .p1_ready(fx_p1_ready),
    .RW(fx_rw), .DA(fx_da), .D_Data(fx_d),
    .AA(aa), .BA(ba), .A_Data_rf(a_rf), .B_Data_rf(b_rf),
    .A_Data(fx_a), .B_Data(fx_b), .conflict_cnt(fx_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // advance one clock; return 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [4:0] da0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] da1, input logic [31:0] d1);
    p0_valid = v0; p0_da = da0; p0_data = d0;
    p1_valid = v1; p1_da = da1; p1_data = d1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    aa = 5'd0; ba = 5'd0; a_rf = 32'd0; b_rf = 32'd0;
    reset_n = 1'b0;
    drive(1'b1, 5'd3, 32'h0000_0003, 1'b1, 5'd4, 32'h0000_0004);

    // reset state, with requests already asserted
    #2;
    chk("rst_p0_ready", {31'd0, rr_p0_ready}, 32'd0);
    chk("rst_p1_ready", {31'd0, rr_p1_ready}, 32'd0);
    chk("rst_rw", {31'd0, rr_rw}, 32'd0);
    chk("rst_da", {27'd0, rr_da}, 32'd0);
    chk("rst_d", rr_d, 32'd0);
    chk("rst_cnt", {24'd0, rr_cnt}, 32'd0);
    step();
    chk("rst_cnt_held", {24'd0, rr_cnt}, 32'd0);
    do_reset();

    // round-robin vectors; outputs checked one edge later
    tbl[0]  = '{1'b1, 5'd1,  32'h1111_1111, 1'b1, 5'd2,  32'h2222_2222, 1'b1, 1'b0, 1'b1, 5'd1,  32'h1111_1111};
    tbl[1]  = '{1'b1, 5'd1,  32'h1111_1111, 1'b1, 5'd2,  32'h2222_2222, 1'b0, 1'b1, 1'b1, 5'd2,  32'h2222_2222};
    tbl[2]  = '{1'b1, 5'd1,  32'h1111_1111, 1'b1, 5'd2,  32'h2222_2222, 1'b1, 1'b0, 1'b1, 5'd1,  32'h1111_1111};
    tbl[3]  = '{1'b1, 5'd1,  32'h1111_1111, 1'b1, 5'd2,  32'h2222_2222, 1'b0, 1'b1, 1'b1, 5'd2,  32'h2222_2222};
    tbl[4]  = '{1'b1, 5'd5,  32'hDEAD_BEEF, 1'b0, 5'd0,  32'h0000_0000, 1'b1, 1'b0, 1'b1, 5'd5,  32'hDEAD_BEEF};
    tbl[5]  = '{1'b0, 5'd0,  32'h0000_0000, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 1'b0, 1'b0, 5'd5,  32'hDEAD_BEEF};
    tbl[6]  = '{1'b0, 5'd0,  32'h0000_0000, 1'b1, 5'd0,  32'h1234_5678, 1'b0, 1'b1, 1'b0, 5'd5,  32'hDEAD_BEEF};
    tbl[7]  = '{1'b1, 5'd3,  32'h3333_3333, 1'b1, 5'd4,  32'h4444_4444, 1'b1, 1'b0, 1'b1, 5'd3,  32'h3333_3333};
    tbl[8]  = '{1'b0, 5'd0,  32'h0000_0000, 1'b1, 5'd4,  32'h4444_4444, 1'b0, 1'b1, 1'b1, 5'd4,  32'h4444_4444};
    tbl[9]  = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0, 5'd0,  32'h0000_0000, 1'b1, 1'b0, 1'b1, 5'd31, 32'hFFFF_FFFF};
    tbl[10] = '{1'b1, 5'd9,  32'hAAAA_0000, 1'b1, 5'd9,  32'hBBBB_0000, 1'b0, 1'b1, 1'b1, 5'd9,  32'hBBBB_0000};
    tbl[11] = '{1'b1, 5'd9,  32'hAAAA_0000, 1'b1, 5'd9,  32'hBBBB_0000, 1'b1, 1'b0, 1'b1, 5'd9,  32'hAAAA_0000};
    tbl[12] = '{1'b0, 5'd0,  32'h0000_0000, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 1'b0, 1'b0, 5'd9,  32'hAAAA_0000};

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].v0, tbl[i].da0, tbl[i].d0, tbl[i].v1, tbl[i].da1, tbl[i].d1);
      #3;
      chk($sformatf("v%0d_p0_ready", i), {31'd0, rr_p0_ready}, {31'd0, tbl[i].er0});
      chk($sformatf("v%0d_p1_ready", i), {31'd0, rr_p1_ready}, {31'd0, tbl[i].er1});
      step();
      chk($sformatf("v%0d_rw", i), {31'd0, rr_rw}, {31'd0, tbl[i].erw});
      chk($sformatf("v%0d_da", i), {27'd0, rr_da}, {27'd0, tbl[i].eda});
      chk($sformatf("v%0d_d", i), rr_d, tbl[i].ed);
      if (i == 3) chk("rr_cnt_after_4", {24'd0, rr_cnt}, 32'd4);
    end
    chk("rr_cnt_after_table", {24'd0, rr_cnt}, 32'd7);

    // forwarding during the RW cycle
    drive(1'b1, 5'd7, 32'hA5A5_A5A5, 1'b0, 5'd0, 32'd0);
    step();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    aa = 5'd7; a_rf = 32'h0000_0007; ba = 5'd3; b_rf = 32'h0000_0008;
    #1;
    chk("byp_rw", {31'd0, rr_rw}, 32'd1);
`ifdef WB_BYPASS_EN
    chk("byp_a_hit", rr_a, 32'hA5A5_A5A5);
`else
    chk("byp_a_hit", rr_a, 32'h0000_0007);
`endif
    chk("byp_b_miss", rr_b, 32'h0000_0008);
    aa = 5'd6; a_rf = 32'h0000_0006;
    #1;
    chk("byp_a_miss", rr_a, 32'h0000_0006);
    step();
    aa = 5'd7; a_rf = 32'h0000_0077;
    #1;
    chk("byp_a_after_rw", rr_a, 32'h0000_0077);

    // back-to-back writes, one per cycle
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 5'(i + 1), 32'h1000_0000 + 32'(i), 1'b0, 5'd0, 32'd0);
      exp_q.push_back({5'(i + 1), 32'h1000_0000 + 32'(i)});
      step();
      chk($sformatf("b2b%0d_rw", i), {31'd0, rr_rw}, 32'd1);
      if (exp_q.size() > 0) begin
        logic [36:0] e;
        e = exp_q.pop_front();
        chk($sformatf("b2b%0d_da", i), {27'd0, rr_da}, {27'd0, e[36:32]});
        chk($sformatf("b2b%0d_d", i), rr_d, e[31:0]);
      end
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step();
    chk("b2b_idle_rw", {31'd0, rr_rw}, 32'd0);
    chk("b2b_q_empty", exp_q.size(), 32'd0);

    // fixed priority
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd1, 32'h0000_00A1, 1'b1, 5'd2, 32'h0000_00B2);
      #3;
      chk($sformatf("fx%0d_p0_ready", i), {31'd0, fx_p0_ready}, 32'd1);
      chk($sformatf("fx%0d_p1_ready", i), {31'd0, fx_p1_ready}, 32'd0);
      step();
      chk($sformatf("fx%0d_da", i), {27'd0, fx_da}, 32'd1);
    end
    drive(1'b0, 5'd1, 32'h0000_00A1, 1'b1, 5'd2, 32'h0000_00B2);
    #1;
    chk("fx_p1_alone_ready", {31'd0, fx_p1_ready}, 32'd1);
    step();
    chk("fx_p1_alone_da", {27'd0, fx_da}, 32'd2);
    chk("fx_p1_alone_d", fx_d, 32'h0000_00B2);
    chk("fx_cnt", {24'd0, fx_cnt}, 32'd3);

    // reset while a write sits in the output stage
    drive(1'b1, 5'd12, 32'hCAFE_F00D, 1'b0, 5'd0, 32'd0);
    step();
    chk("pend_rw_before", {31'd0, rr_rw}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("pend_rw_async", {31'd0, rr_rw}, 32'd0);
    chk("pend_da_async", {27'd0, rr_da}, 32'd0);
    chk("pend_d_async", rr_d, 32'd0);
    chk("pend_ready_in_rst", {31'd0, rr_p0_ready}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("pend_rw_hold%0d", i), {31'd0, rr_rw}, 32'd0);
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step();
    reset_n = 1'b1;
    step();
    chk("pend_rw_after", {31'd0, rr_rw}, 32'd0);

    // contention counter saturation
    do_reset();
    drive(1'b1, 5'd1, 32'd1, 1'b1, 5'd2, 32'd2);
    for (int i = 0; i < 254; i++) step();
    chk("cnt_254", {24'd0, rr_cnt}, 32'd254);
    for (int i = 0; i < 46; i++) step();
    chk("cnt_sat", {24'd0, rr_cnt}, 32'd255);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
